// File: rtl/battleship_pkg.sv
// Shared types and helpers for the battleship ship-count selection path.
package battleship_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      CHECK   = 2'd2,
      DONE    = 2'd3
   } sel_state_t;

   localparam int unsigned MIN_SHIPS_DEF = 1;
   localparam int unsigned MAX_SHIPS_DEF = 5;

   function automatic logic in_range(input int unsigned amt,
                                     input int unsigned lo,
                                     input int unsigned hi);
      return (amt >= lo) && (amt <= hi);
   endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus stability counter for one slide switch.
// Emits a single-cycle pulse when the debounced level falls from 1 to 0.
module switch_debouncer #(
   parameter int unsigned DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic fall_o
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             meta_q, sync_q;
   logic             level_q, level_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         fall_q  <= 1'b0;
      end else begin
         meta_q  <= raw_i;
         sync_q  <= meta_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         fall_q  <= fall_d;
      end
   end

   // The counter tracks how long the synced value has disagreed with the accepted level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      fall_d  = 1'b0;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
            fall_d  = level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign fall_o = fall_q;

endmodule

// File: rtl/ship_amount_selector.sv
// Collects per-player ship-count proposals, range-checks them and releases the game
// count only when every player has locked the same value.
module ship_amount_selector
   import battleship_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS  = 2,
   parameter int unsigned AMT_W        = 3,
   parameter int unsigned MIN_SHIPS    = MIN_SHIPS_DEF,
   parameter int unsigned MAX_SHIPS    = MAX_SHIPS_DEF,
   parameter int unsigned DEBOUNCE_CYC = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         decision,
   input  logic [NUM_PLAYERS*AMT_W-1:0] player_amount_ships,
   input  logic [NUM_PLAYERS-1:0]       player_confirm_amount,
   output logic [AMT_W-1:0]             amount_ships_game,
   output logic [NUM_PLAYERS-1:0]       player_locked,
   output logic                         amount_invalid,
   output logic                         amount_mismatch,
   output logic                         ships_located,
   output sel_state_t                   state_o
);

   logic [NUM_PLAYERS-1:0] fall;

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_deb
      switch_debouncer #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_deb (
         .clk    (clk),
         .rst_n  (rst),
         .raw_i  (player_confirm_amount[p]),
         .fall_o (fall[p])
      );
   end

   sel_state_t             state_q, state_d;
   logic [NUM_PLAYERS-1:0] locked_q, locked_d;
   logic [AMT_W-1:0]       slot_q [NUM_PLAYERS];
   logic [AMT_W-1:0]       slot_d [NUM_PLAYERS];
   logic [AMT_W-1:0]       game_q, game_d;
   logic                   located_q, located_d;
   logic                   invalid_q, invalid_d;
   logic                   mismatch_q, mismatch_d;
   logic                   all_eq;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         locked_q   <= '0;
         game_q     <= '0;
         located_q  <= 1'b0;
         invalid_q  <= 1'b0;
         mismatch_q <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) slot_q[p] <= '0;
      end else begin
         state_q    <= state_d;
         locked_q   <= locked_d;
         game_q     <= game_d;
         located_q  <= located_d;
         invalid_q  <= invalid_d;
         mismatch_q <= mismatch_d;
         for (int p = 0; p < NUM_PLAYERS; p++) slot_q[p] <= slot_d[p];
      end
   end

   always_comb begin
      all_eq = 1'b1;
      for (int p = 1; p < NUM_PLAYERS; p++) begin
         if (slot_q[p] != slot_q[0]) all_eq = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      locked_d   = locked_q;
      game_d     = game_q;
      located_d  = located_q;
      invalid_d  = 1'b0;
      mismatch_d = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) slot_d[p] = slot_q[p];

      case (state_q)
         IDLE: begin
            if (decision) state_d = COLLECT;
         end
         COLLECT: begin
            if (!decision) begin
               state_d  = IDLE;
               locked_d = '0;
            end else if (&locked_q) begin
               state_d = CHECK;
            end else begin
               // Every unlocked player is handled independently so simultaneous confirms all land.
               for (int p = 0; p < NUM_PLAYERS; p++) begin
                  if (fall[p] && !locked_q[p]) begin
                     slot_d[p] = player_amount_ships[p*AMT_W +: AMT_W];
                     if (in_range(int'(player_amount_ships[p*AMT_W +: AMT_W]),
                                  MIN_SHIPS, MAX_SHIPS)) begin
                        locked_d[p] = 1'b1;
                     end else begin
                        invalid_d = 1'b1;
                     end
                  end
               end
            end
         end
         CHECK: begin
            if (!decision) begin
               state_d  = IDLE;
               locked_d = '0;
            end else if (all_eq) begin
               state_d   = DONE;
               game_d    = slot_q[0];
               located_d = 1'b1;
            end else begin
               state_d    = COLLECT;
               locked_d   = '0;
               mismatch_d = 1'b1;
            end
         end
         DONE: begin
            if (!decision) begin
               state_d   = IDLE;
               located_d = 1'b0;
               locked_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign amount_ships_game = game_q;
   assign player_locked     = locked_q;
   assign amount_invalid    = invalid_q;
   assign amount_mismatch   = mismatch_q;
   assign ships_located     = located_q;
   assign state_o           = state_q;

endmodule

// File: tb/tb_ship_amount_selector.sv
// Bench for ship_amount_selector: directed latency/corner sequences, a vector table,
// and randomized confirm rounds checked against a round-level reference model.
module tb_ship_amount_selector;
   import battleship_pkg::*;

   localparam int NP  = 2;
   localparam int AW  = 3;
   localparam int MIN = 1;
   localparam int MAX = 5;
   localparam int DB  = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            decision = 1'b0;
   logic [NP*AW-1:0] amounts = '0;
   logic [NP-1:0]    raw = '0;
   logic [AW-1:0]    game;
   logic [NP-1:0]    locked;
   logic             invalid, mismatch, located;
   sel_state_t       state;

   int vectors = 0;
   int miscompares = 0;

   ship_amount_selector #(
      .NUM_PLAYERS (NP), .AMT_W (AW), .MIN_SHIPS (MIN), .MAX_SHIPS (MAX), .DEBOUNCE_CYC (DB)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .decision              (decision),
      .player_amount_ships   (amounts),
      .player_confirm_amount (raw),
      .amount_ships_game     (game),
      .player_locked         (locked),
      .amount_invalid        (invalid),
      .amount_mismatch       (mismatch),
      .ships_located         (located),
      .state_o               (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      decision = 1'b0;
      raw = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   // Raise the chosen switches long enough to be accepted high, then drop them and wait
   // for the whole lock/check sequence, counting every pulse seen on the way.
   task automatic do_round(input logic [1:0] mask, input logic [2:0] a0, input logic [2:0] a1,
                           output int inv_n, output int mis_n);
      inv_n = 0;
      mis_n = 0;
      amounts = {a1, a0};
      raw = mask;
      repeat (8) begin
         tick();
         inv_n += int'(invalid);
         mis_n += int'(mismatch);
      end
      raw = '0;
      repeat (12) begin
         tick();
         inv_n += int'(invalid);
         mis_n += int'(mismatch);
      end
   endtask

   // Reference model, one confirm round at a time.
   int m_locked, m_located, m_game, m_done;
   int m_slot [NP];

   task automatic model_reset();
      m_locked = 0; m_located = 0; m_game = 0; m_done = 0;
      for (int p = 0; p < NP; p++) m_slot[p] = 0;
   endtask

   task automatic model_round(input logic [1:0] mask, input int a0, input int a1,
                              output int e_inv, output int e_mis);
      int amt [NP];
      amt[0] = a0;
      amt[1] = a1;
      e_inv = 0;
      e_mis = 0;
      if (m_done == 0) begin
         for (int p = 0; p < NP; p++) begin
            if (mask[p] && !m_locked[p]) begin
               m_slot[p] = amt[p];
               if (amt[p] >= MIN && amt[p] <= MAX) m_locked |= (1 << p);
               else e_inv = 1;
            end
         end
         if (m_locked == (1 << NP) - 1) begin
            if (m_slot[0] == m_slot[1]) begin
               m_done = 1; m_located = 1; m_game = m_slot[0];
            end else begin
               e_mis = 1; m_locked = 0;
            end
         end
      end
   endtask

   typedef struct {
      logic [1:0] mask;
      logic [2:0] a0, a1;
      logic [1:0] exp_locked;
      logic       exp_located;
      logic [2:0] exp_game;
      int         exp_inv, exp_mis;
      sel_state_t exp_state;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int inv_n, mis_n, e_inv, e_mis, lock_at, loc_at;
      logic [1:0] mask;
      logic [2:0] a0, a1;

      rst = 1'b0;
      #3;
      check("reset_game", game, 0);
      check("reset_locked", locked, 0);
      check("reset_located", located, 0);
      check("reset_pulses", {invalid, mismatch}, 0);
      check("reset_state", state, IDLE);
      do_reset();

      // Agreement with exact latency from raw release.
      decision = 1'b1;
      amounts = {3'd3, 3'd3};
      tick();
      check("idle_to_collect", state, COLLECT);
      raw = 2'b11;
      repeat (10) tick();
      raw = 2'b00;
      lock_at = -1;
      loc_at = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (lock_at < 0 && locked == 2'b11) lock_at = i;
         if (loc_at < 0 && located) loc_at = i;
      end
      check("lock_latency", lock_at, DB + 3);
      check("located_latency", loc_at, DB + 5);
      check("agree_game", game, 3);
      check("agree_state", state, DONE);

      // Re-confirm while DONE must not disturb the held count.
      do_round(2'b01, 3'd1, 3'd3, inv_n, mis_n);
      check("hold_game", game, 3);
      check("hold_located", located, 1);
      decision = 1'b0;
      tick();
      tick();
      check("release_located", located, 0);
      check("release_locked", locked, 0);
      check("release_game", game, 3);
      check("release_state", state, IDLE);

      // Asynchronous reset mid-COLLECT.
      decision = 1'b1;
      tick();
      do_round(2'b01, 3'd2, 3'd0, inv_n, mis_n);
      check("pre_reset_locked", locked, 2'b01);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_game", game, 0);
      check("async_rst_locked", locked, 0);
      check("async_rst_state", state, IDLE);
      #2;
      rst = 1'b1;
      tick();

      // Bounce and glitch rejection.
      decision = 1'b1;
      amounts = {3'd0, 3'd5};
      tick();
      inv_n = 0;
      for (int i = 0; i < 4; i++) begin
         raw[0] = (i % 2 == 0);
         tick();
         inv_n += int'(invalid) + int'(locked[0]);
      end
      raw[0] = 1'b1;
      repeat (8) tick();
      raw[0] = 1'b0;
      repeat (3) tick();
      raw[0] = 1'b1;
      repeat (12) begin
         tick();
         inv_n += int'(invalid) + int'(locked[0]);
      end
      check("bounce_no_effect", inv_n, 0);
      check("bounce_locked", locked, 0);
      raw[0] = 1'b0;
      repeat (12) tick();
      check("settled_fall_locks", locked, 2'b01);

      // Abort from COLLECT.
      decision = 1'b0;
      tick();
      check("abort_locked", locked, 0);
      check("abort_state", state, IDLE);
      check("abort_pulses", {invalid, mismatch}, 0);
      decision = 1'b1;
      tick();

      // Directed table from a fresh reset.
      tbl[0] = '{2'b01, 3'd0, 3'd0, 2'b00, 1'b0, 3'd0, 1, 0, COLLECT};
      tbl[1] = '{2'b01, 3'd6, 3'd0, 2'b00, 1'b0, 3'd0, 1, 0, COLLECT};
      tbl[2] = '{2'b01, 3'd5, 3'd0, 2'b01, 1'b0, 3'd0, 0, 0, COLLECT};
      tbl[3] = '{2'b10, 3'd5, 3'd4, 2'b00, 1'b0, 3'd0, 0, 1, COLLECT};
      tbl[4] = '{2'b11, 3'd2, 3'd4, 2'b00, 1'b0, 3'd0, 0, 1, COLLECT};
      tbl[5] = '{2'b11, 3'd3, 3'd3, 2'b11, 1'b1, 3'd3, 0, 0, DONE};
      tbl[6] = '{2'b01, 3'd1, 3'd3, 2'b11, 1'b1, 3'd3, 0, 0, DONE};
      do_reset();
      decision = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         do_round(tbl[i].mask, tbl[i].a0, tbl[i].a1, inv_n, mis_n);
         check($sformatf("tbl%0d_inv", i), inv_n, tbl[i].exp_inv);
         check($sformatf("tbl%0d_mis", i), mis_n, tbl[i].exp_mis);
         check($sformatf("tbl%0d_locked", i), locked, tbl[i].exp_locked);
         check($sformatf("tbl%0d_located", i), located, tbl[i].exp_located);
         check($sformatf("tbl%0d_game", i), game, tbl[i].exp_game);
         check($sformatf("tbl%0d_state", i), state, tbl[i].exp_state);
      end

      // Randomized rounds against the reference model.
      do_reset();
      model_reset();
      decision = 1'b1;
      tick();
      for (int r = 0; r < 60; r++) begin
         if ($urandom_range(0, 9) == 0) begin
            decision = 1'b0;
            tick();
            tick();
            m_locked = 0; m_located = 0; m_done = 0;
            check($sformatf("rnd%0d_abort_locked", r), locked, m_locked);
            check($sformatf("rnd%0d_abort_located", r), located, m_located);
            check($sformatf("rnd%0d_abort_game", r), game, m_game);
            decision = 1'b1;
            tick();
         end
         mask = 2'($urandom_range(1, 3));
         a0 = 3'($urandom_range(0, 7));
         a1 = ($urandom_range(0, 1) == 1) ? a0 : 3'($urandom_range(0, 7));
         model_round(mask, int'(a0), int'(a1), e_inv, e_mis);
         do_round(mask, a0, a1, inv_n, mis_n);
         check($sformatf("rnd%0d_inv", r), inv_n, e_inv);
         check($sformatf("rnd%0d_mis", r), mis_n, e_mis);
         check($sformatf("rnd%0d_locked", r), locked, m_locked);
         check($sformatf("rnd%0d_located", r), located, m_located);
         check($sformatf("rnd%0d_game", r), game, m_game);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
